fetch_ctrl: RTL and testbench
=============================

FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter: N, default 64, width of PC and branch target.
REQ-002 clk  input  1  pipeline clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high; clears all state immediately, independent of clk.
REQ-004 PCSrc_F  input  1  redirect request (branch taken) from the decision stage.
REQ-005 PCBranch_F  input  N  redirect target; bits [1:0] are ignored and forced to 0.
REQ-006 stall_D  input  1  decode stage cannot accept an instruction this cycle.
REQ-007 imem_ready  input  1  instruction memory completes the current transaction at this edge.
REQ-008 imem_rdata  input  32  instruction word; valid only when imem_ready=1.
REQ-009 imem_req  output  1  transaction request to instruction memory.
REQ-010 imem_addr_F  output  N  fetch address; equals the internal PC register.
REQ-011 instr_F  output  32  last accepted instruction word (registered).
REQ-012 instr_valid_F  output  1  registered one-cycle pulse: instr_F is new and must be consumed by IF/ID.
REQ-013 flush_IF  output  1  registered one-cycle pulse: a redirect was accepted, so IF/ID must be squashed.

Function
REQ-014 FSM states: BOOT, WAIT, HOLD, SQUASH; state is registered.
REQ-015 Memory protocol: while imem_req=1, imem_addr_F shall stay stable until the edge where imem_ready=1 completes the transaction.
REQ-016 BOOT: imem_req=0, PC=0; unconditionally -> WAIT on the next edge.
REQ-017 WAIT: imem_req=1.
- WAIT, imem_ready=1, PCSrc_F=0, stall_D=0: instr_F<=imem_rdata; instr_valid_F=1 next cycle; PC<=PC+4; stay in WAIT.
- WAIT, imem_ready=1, PCSrc_F=0, stall_D=1: instr_F<=imem_rdata; no valid pulse; PC unchanged; -> HOLD.
REQ-018 WAIT, imem_ready=1, PCSrc_F=1: data discarded (instr_F unchanged, no valid); PC<=PCBranch_F; flush_IF=1 next cycle; stay in WAIT.
REQ-019 WAIT, imem_ready=0, PCSrc_F=1: target register<=PCBranch_F; flush_IF=1 next cycle; PC unchanged; -> SQUASH.
REQ-020 WAIT, imem_ready=0, PCSrc_F=0: no change; zero-wait memory (imem_ready tied 1) shall yield one instruction per cycle.
REQ-021 HOLD: imem_req=0; PC and instr_F held.
- HOLD, stall_D=0, PCSrc_F=0: instr_valid_F=1 next cycle; PC<=PC+4; -> WAIT.
- HOLD, PCSrc_F=1: held word discarded; PC<=PCBranch_F; flush_IF=1; -> WAIT.
REQ-022 SQUASH: imem_req=1 at the old address.
- SQUASH, imem_ready=1: data discarded; PC<=target register; -> WAIT.
- SQUASH, further PCSrc_F=1: target register overwritten (last redirect wins); flush_IF pulses again.
REQ-023 Priority: PCSrc_F over stall_D in every state; instr_valid_F and flush_IF are never both 1 in the same cycle.
REQ-024 Arithmetic: PC+4 is modulo 2^N; PC=2^N-4 wraps to 0 without error.
REQ-025 No instruction is delivered twice and none is skipped except by redirect.

Reset
REQ-026 While reset=1: state=BOOT, PC=0, target register=0, imem_req=0, imem_addr_F=0, instr_F=0, instr_valid_F=0, flush_IF=0.
REQ-027 Reset asserted mid-transaction (WAIT or SQUASH) abandons that transaction; the first request after release is at address 0.
REQ-028 After reset deasserts: one BOOT cycle, then imem_req=1 at address 0.

Verification
REQ-029 Reset for 5 cycles with imem_ready=1, then release -> imem_addr_F sequence 0,0(BOOT),0,4,8; instr_valid_F pulses once per address from 0 onward.
REQ-030 imem_ready=0 for 3 cycles at address 4 -> imem_req=1 and address 4 held, no valid; when ready=1 with rdata=0xF84003E1 -> instr_F=0xF84003E1 with valid, address 8.
REQ-031 At address 8, ready=1, PCSrc_F=1, PCBranch_F=20 -> no valid for 8, flush_IF pulse, addresses 20 then 24.
REQ-032 At address 12, ready=0, PCSrc_F=1, PCBranch_F=40 -> SQUASH, address 12 held until ready, data discarded, then address 40, exactly one flush_IF pulse.
REQ-033 At address 16, ready=1, stall_D=1 for 2 cycles -> HOLD with imem_req=0 and address 16, no valid; on stall release -> single valid pulse carrying the word from 16, then address 20.
REQ-034 PCBranch_F=0xFFFF_FFFF_FFFF_FFFE via redirect -> address 0xFFFF_FFFF_FFFF_FFFC, next address 0; async reset asserted mid-WAIT -> all outputs 0 before the next clock edge.

Source files
------------

// File: rtl/fetch_ctrl_if.sv
// Fetch controller bus: redirect/stall inputs, instruction-memory handshake
// and the IF/ID-facing instruction outputs.
interface fetch_ctrl_if #(
    parameter int N = 64
);
    logic          PCSrc_F;
    logic [N-1:0]  PCBranch_F;
    logic          stall_D;
    logic          imem_ready;
    logic [31:0]   imem_rdata;
    logic          imem_req;
    logic [N-1:0]  imem_addr_F;
    logic [31:0]   instr_F;
    logic          instr_valid_F;
    logic          flush_IF;

    modport master (
        input  PCSrc_F, PCBranch_F, stall_D, imem_ready, imem_rdata,
        output imem_req, imem_addr_F, instr_F, instr_valid_F, flush_IF
    );

    modport slave (
        output PCSrc_F, PCBranch_F, stall_D, imem_ready, imem_rdata,
        input  imem_req, imem_addr_F, instr_F, instr_valid_F, flush_IF
    );
endinterface

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: walks the PC, runs the instruction-memory
// request/ready handshake, and handles decode stalls and branch redirects.
//
//   state  | meaning
//   BOOT   | first cycle after reset, no request, PC = 0
//   WAIT   | request outstanding at PC, waiting for imem_ready
//   HOLD   | word fetched but decode stalled; word parked in instr_F
//   SQUASH | redirect arrived mid-transaction; finish old access, discard it
module fetch_ctrl #(
    parameter int N = 64
) (
    input  logic        clk,
    input  logic        reset,
    fetch_ctrl_if.master bus
);
    typedef enum logic [1:0] {BOOT, WAIT, HOLD, SQUASH} state_t;

    localparam logic [N-1:0] ALIGN_MASK = ~N'(3);
    localparam logic [N-1:0] PC_INC     = N'(4);

    state_t        state;
    logic [N-1:0]  pc;
    logic [N-1:0]  target;
    logic          req;
    logic [31:0]   instr;
    logic          valid;
    logic          flush;
    logic [N-1:0]  branch;

    assign branch            = bus.PCBranch_F & ALIGN_MASK;
    assign bus.imem_req      = req;
    assign bus.imem_addr_F   = pc;
    assign bus.instr_F       = instr;
    assign bus.instr_valid_F = valid;
    assign bus.flush_IF      = flush;

    // Fetch FSM with registered outputs; redirect always beats stall.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= BOOT;
            pc     <= '0;
            target <= '0;
            req    <= 1'b0;
            instr  <= '0;
            valid  <= 1'b0;
            flush  <= 1'b0;
        end else begin
            valid <= 1'b0;
            flush <= 1'b0;
            case (state)
                BOOT: begin
                    pc    <= '0;
                    req   <= 1'b1;
                    state <= WAIT;
                end
                WAIT: begin
                    if (bus.PCSrc_F) begin
                        flush <= 1'b1;
                        if (bus.imem_ready) begin
                            pc <= branch;
                        end else begin
                            // Address must stay put until the access completes.
                            target <= branch;
                            state  <= SQUASH;
                        end
                    end else if (bus.imem_ready) begin
                        instr <= bus.imem_rdata;
                        if (bus.stall_D) begin
                            req   <= 1'b0;
                            state <= HOLD;
                        end else begin
                            valid <= 1'b1;
                            pc    <= pc + PC_INC;
                        end
                    end
                end
                HOLD: begin
                    if (bus.PCSrc_F) begin
                        flush <= 1'b1;
                        pc    <= branch;
                        req   <= 1'b1;
                        state <= WAIT;
                    end else if (!bus.stall_D) begin
                        valid <= 1'b1;
                        pc    <= pc + PC_INC;
                        req   <= 1'b1;
                        state <= WAIT;
                    end
                end
                SQUASH: begin
                    if (bus.PCSrc_F) begin
                        flush  <= 1'b1;
                        target <= branch;
                    end
                    if (bus.imem_ready) begin
                        // Last redirect wins, even one arriving on this edge.
                        pc    <= bus.PCSrc_F ? branch : target;
                        state <= WAIT;
                    end
                end
                default: begin
                    req   <= 1'b0;
                    state <= BOOT;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl; accepted words go into a scoreboard queue
// and are popped whenever the controller raises instr_valid_F.
module tb_fetch_ctrl;
    logic clk;
    logic reset;
    int   n_cmp;
    int   n_err;
    logic [31:0] sb[$];

    fetch_ctrl_if #(.N(64)) bus ();

    fetch_ctrl #(.N(64)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic outs(input string tag, input logic ev, input logic ef,
                        input logic ereq, input logic [63:0] ea);
        chk({tag, ".valid"}, 64'(bus.instr_valid_F), 64'(ev));
        chk({tag, ".flush"}, 64'(bus.flush_IF), 64'(ef));
        chk({tag, ".req"}, 64'(bus.imem_req), 64'(ereq));
        chk({tag, ".addr"}, bus.imem_addr_F, ea);
        if (bus.instr_valid_F === 1'b1) begin
            n_cmp++;
            assert (sb.size() > 0) else begin
                n_err++;
                $error("FAIL %s.sb_underflow observed=valid expected=no_valid", tag);
            end
            if (sb.size() > 0) chk({tag, ".instr"}, 64'(bus.instr_F), 64'(sb.pop_front()));
        end
    endtask

    // One clock: drive inputs, optionally log the word as expected, check after edge.
    task automatic cyc(input string tag, input logic ps, input logic [63:0] br,
                       input logic st, input logic rdy, input logic [31:0] rd,
                       input logic push, input logic ev, input logic ef,
                       input logic ereq, input logic [63:0] ea);
        bus.PCSrc_F    = ps;
        bus.PCBranch_F = br;
        bus.stall_D    = st;
        bus.imem_ready = rdy;
        bus.imem_rdata = rd;
        if (push) sb.push_back(rd);
        @(posedge clk);
        #1;
        outs(tag, ev, ef, ereq, ea);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        reset = 1'b1;
        bus.PCSrc_F    = 1'b0;
        bus.PCBranch_F = '0;
        bus.stall_D    = 1'b0;
        bus.imem_ready = 1'b1;
        bus.imem_rdata = 32'h0;
        #1;
        outs("rst_async", 0, 0, 0, 64'd0);
        chk("rst_async.instr", 64'(bus.instr_F), 64'd0);
        for (int i = 0; i < 5; i++) cyc("rst_hold", 0, 0, 0, 1, 32'h1111_1111, 0, 0, 0, 0, 64'd0);
        reset = 1'b0;

        // Boot, then zero-wait fetch from 0.
        cyc("boot",      0, 0, 0, 1, 32'h2222_2222, 0, 0, 0, 1, 64'd0);
        cyc("fetch0",    0, 0, 0, 1, 32'hA000_0000, 1, 1, 0, 1, 64'd4);
        // Memory wait states at 4.
        for (int i = 0; i < 3; i++) cyc("wait4", 0, 0, 0, 0, 32'hBAD0_0004, 0, 0, 0, 1, 64'd4);
        cyc("fetch4",    0, 0, 0, 1, 32'hF840_03E1, 1, 1, 0, 1, 64'd8);
        // Redirect on a completing access.
        cyc("redir8",    1, 64'd20, 0, 1, 32'hBAD0_0008, 0, 0, 1, 1, 64'd20);
        cyc("fetch20",   0, 0, 0, 1, 32'hA000_0014, 1, 1, 0, 1, 64'd24);
        cyc("redir24",   1, 64'd12, 0, 1, 32'hBAD0_0018, 0, 0, 1, 1, 64'd12);
        // Redirect while the access to 12 is still pending.
        cyc("sq12_a",    1, 64'd40, 0, 0, 32'hBAD0_000C, 0, 0, 1, 1, 64'd12);
        cyc("sq12_b",    0, 0, 0, 0, 32'hBAD0_000C, 0, 0, 0, 1, 64'd12);
        cyc("sq12_done", 0, 0, 0, 1, 32'hDEAD_000C, 0, 0, 0, 1, 64'd40);
        // Two redirects during one squash: the later one wins.
        cyc("sq40_a",    1, 64'd100, 0, 0, 32'hBAD0_0028, 0, 0, 1, 1, 64'd40);
        cyc("sq40_b",    1, 64'd200, 0, 0, 32'hBAD0_0028, 0, 0, 1, 1, 64'd40);
        cyc("sq40_done", 0, 0, 0, 1, 32'hDEAD_0028, 0, 0, 0, 1, 64'd200);
        cyc("redir200",  1, 64'd16, 0, 1, 32'hBAD0_00C8, 0, 0, 1, 1, 64'd16);
        // Decode stall at 16: word parked, delivered once on release.
        cyc("stall16_a", 0, 0, 1, 1, 32'hA000_0010, 1, 0, 0, 0, 64'd16);
        cyc("stall16_b", 0, 0, 1, 1, 32'hBAD0_0010, 0, 0, 0, 0, 64'd16);
        cyc("rel16",     0, 0, 0, 1, 32'hBAD0_0010, 0, 1, 0, 1, 64'd20);
        cyc("fetch20b",  0, 0, 0, 1, 32'hA000_0020, 1, 1, 0, 1, 64'd24);
        // Redirect while holding beats the stall.
        cyc("stall24",   0, 0, 1, 1, 32'hBAD0_0024, 0, 0, 0, 0, 64'd24);
        cyc("hold_redir",1, 64'd48, 1, 1, 32'hBAD0_0024, 0, 0, 1, 1, 64'd48);
        cyc("zw48",      0, 0, 0, 1, 32'hA000_0030, 1, 1, 0, 1, 64'd52);
        cyc("zw52",      0, 0, 0, 1, 32'hA000_0034, 1, 1, 0, 1, 64'd56);
        cyc("zw56",      0, 0, 0, 1, 32'hA000_0038, 1, 1, 0, 1, 64'd60);
        // Misaligned target gets its low bits cleared; PC wraps to 0.
        cyc("redir_top", 1, 64'hFFFF_FFFF_FFFF_FFFE, 0, 1, 32'hBAD0_003C, 0, 0, 1, 1,
            64'hFFFF_FFFF_FFFF_FFFC);
        cyc("wrap",      0, 0, 0, 1, 32'hA000_FFFC, 1, 1, 0, 1, 64'd0);
        cyc("fetch0b",   0, 0, 0, 1, 32'hA000_0100, 1, 1, 0, 1, 64'd4);
        cyc("pend4",     0, 0, 0, 0, 32'hBAD0_0104, 0, 0, 0, 1, 64'd4);
        // Asynchronous reset in the middle of a pending access.
        reset = 1'b1;
        #1;
        outs("rst_mid", 0, 0, 0, 64'd0);
        chk("rst_mid.instr", 64'(bus.instr_F), 64'd0);
        cyc("rst_mid_hold", 0, 0, 0, 1, 32'h3333_3333, 0, 0, 0, 0, 64'd0);
        reset = 1'b0;
        cyc("boot2",     0, 0, 0, 1, 32'h4444_4444, 0, 0, 0, 1, 64'd0);
        cyc("fetch0c",   0, 0, 0, 1, 32'hA000_0200, 1, 1, 0, 1, 64'd4);
        cyc("idle",      0, 0, 0, 0, 32'h0, 0, 0, 0, 1, 64'd4);
        chk("sb_drained", 64'(sb.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
